mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
// - Memory-mapped UART transmitter that acts as a responder on the CPU data bus (mem_addr/mem_wr_sig/mem_wr_data/mem_rd_data).
// - CPU stores fill an internal TX FIFO; a serializer shifts each byte out on tx as 8N1 frames, LSB first.
// - Sits beside ram on the data bus. The top level muxes rd_data using hit.
// PARAMETERS
// - BASE_ADDR    32'h0000_1000  base of the 16-byte register window; addr[31:4] must equal BASE_ADDR[31:4]
// - FIFO_DEPTH   8              TX FIFO entries; power of two, >= 2
// - DEFAULT_DIV  16             reset value of DIV (clocks per bit)
// PORTS
// - clk      in   1   system clock, rising edge
// - reset_n  in   1   asynchronous reset, active low
// - wr_sig   in   1   store strobe from cpu, sampled on rising edge
// - wr_data  in   32  store data
// - addr     in   32  byte address from cpu
// - rd_data  out  32  read data, combinational from addr; 0 when hit=0
// - hit      out  1   combinational: addr falls inside the register window
// - tx       out  1   serial output, idles high
// BEHAVIOUR
// - Register map, offset addr[3:2]:
//   - 0 DATA: write pushes wr_data[7:0]; reads 0.
//   - 1 STATUS: read {28'b0, ovf, busy, empty, full}; write 1 to bit3 clears ovf.
//   - 2 DIV: R/W, bits [15:0]; upper bits read 0.
//   - 3 reserved: reads 0, writes ignored.
//   - addr[1:0] ignored. Writes are taken only when wr_sig=1 and hit=1.
// - Reset (async, immediate, including mid-frame):
//   - tx=1; FSM=IDLE; FIFO empty (full=0, empty=1); ovf=0; DIV=DEFAULT_DIV.
//   - Counters are cleared; rd_data/hit follow addr.
// - FIFO:
//   - Write pointer, read pointer and count each have log2(FIFO_DEPTH) bits, plus one extra bit on count.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - DATA write when full with no pop in the same cycle: byte dropped, ovf<=1 (sticky).
//   - DATA write when full and a pop occurs in the same cycle: push accepted.
//   - Push into empty FIFO: the byte is visible to the FSM on the next cycle.
// - FSM states: IDLE, START, DATA, STOP.
// - IDLE -> START: when FIFO is not empty.
//   - Pop head into shift register; latch DIV into div_q (0 treated as 1).
//   - baud_cnt<=div_q-1; tx<=0 during START.
// - Bit timing: each state-bit lasts exactly div_q cycles; baud_cnt decrements, bit ends at 0.
// - START -> DATA: bit_cnt<=0; tx<=shift[0].
// - DATA: at each bit end, shift right and bit_cnt++; after bit 7 -> STOP with tx<=1.
// - STOP end:
//   - If FIFO is not empty, go straight to START (pop and relatch DIV, no idle gap).
//   - Otherwise go to IDLE.
// - Frame length is 10*div_q cycles.
// - busy=1 when FSM != IDLE.
// - DIV writes mid-frame take effect at the next frame start only.
// - tx is driven from a register (glitch-free). The first start-bit cycle is the cycle after the pop edge.
// - Simultaneous ovf set (dropped write) and STATUS W1C in the same cycle cannot occur (different offsets).
// TESTING
// - Reset: after release, tx=1, STATUS=0x2, DIV read=16, hit=0 for addr=0.
// - DIV=4, write DATA=0x55:
//   - tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
//   - busy=1 for 40 cycles, then STATUS=0x2.
// - DIV=4, 10 back-to-back DATA writes 0x01..0x0A:
//   - Bytes 0x01..0x09 are sent with no idle gap; 0x0A is dropped; STATUS.ovf=1.
//   - Write STATUS=0x8 -> ovf=0.
// - DIV=2 written mid-frame while DIV=4:
//   - Current frame stays at 40 cycles; the next queued frame is 20 cycles.
// - Assert reset_n=0 mid DATA bit:
//   - tx=1 in the same cycle; FIFO emptied; after release no further frame is sent.
// - Window decode:
//   - addr=BASE+0xC reads 0; addr=BASE+0x10 gives hit=0, rd_data=0.
//   - wr_sig=1 outside the window leaves the FIFO unchanged.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
// A 16-byte register window (DATA / STATUS / DIV / reserved) feeds a TX FIFO.
// A serializer drains the FIFO LSB first, each bit lasting div_q clocks.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous reset, active low
//   wr_sig   in   store strobe from the CPU
//   wr_data  in   store data (DATA uses [7:0], DIV uses [15:0], STATUS uses [3])
//   addr     in   byte address from the CPU
//   rd_data  out  combinational read data, 0 outside the window
//   hit      out  combinational window decode
//   tx       out  registered serial line, idles high
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_sig,
    input  logic [31:0] wr_data,
    input  logic [31:0] addr,
    output logic [31:0] rd_data,
    output logic        hit,
    output logic        tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // register file
    logic [15:0] div_reg;
    logic        ovf;

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    // serializer datapath, current and next
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_cnt_d;
    logic [15:0] baud_cnt;
    logic [15:0] baud_d;
    logic [15:0] div_q;
    logic [15:0] div_q_d;
    logic        tx_d;
    logic        bit_end;
    logic [15:0] div_eff;
    logic        busy;

    // bus decode
    logic wr_en;
    logic data_wr;
    logic status_wr;
    logic div_wr;

    // addr[1:0] and the upper store bits carry no meaning in this window
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wr_data[31:16]};

    // Window decode and write strobes
    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en     = wr_sig & hit;
    assign data_wr   = wr_en & (addr[3:2] == OFF_DATA);
    assign status_wr = wr_en & (addr[3:2] == OFF_STATUS);
    assign div_wr    = wr_en & (addr[3:2] == OFF_DIV);

    assign busy = (state_q != S_IDLE);

    // Read mux
    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (addr[3:2])
                OFF_STATUS: rd_data = {28'b0, ovf, busy, empty, full};
                OFF_DIV:    rd_data = {16'b0, div_reg};
                default:    rd_data = '0;
            endcase
        end
    end

    // DIV register and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg <= DEFAULT_DIV;
            ovf     <= 1'b0;
        end else begin
            if (div_wr) begin
                div_reg <= wr_data[15:0];
            end
            if (data_wr && full && !pop) begin
                ovf <= 1'b1;
            end else if (status_wr && wr_data[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    // FIFO status; a pop in the same cycle frees the slot a full push needs
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign push  = data_wr & (~full | pop);
    assign head  = fifo_mem[rd_ptr];

    // FIFO storage, no reset needed: contents are qualified by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_data[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A DIV of zero would never end a bit, so it behaves as one
    assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;
    assign bit_end = (baud_cnt == 16'd0);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_START;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = empty ? S_IDLE : S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: pop strobe and next values of the serializer registers
    always_comb begin
        pop       = 1'b0;
        tx_d      = tx;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt;
        baud_d    = baud_cnt;
        div_q_d   = div_q;
        case (state_q)
            S_IDLE: begin
                pop = ~empty;
            end
            S_START: begin
                if (bit_end) begin
                    baud_d    = div_q - 16'd1;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = div_q - 16'd1;
                    if (bit_cnt == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        // shift_q[1] becomes the new LSB on the wire
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    pop  = ~empty;
                    tx_d = 1'b1;
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
        // Frame start: load byte, snapshot DIV, drive the start bit
        if (pop) begin
            shift_d = head;
            div_q_d = div_eff;
            baud_d  = div_eff - 16'd1;
            tx_d    = 1'b0;
        end
    end

    // Serializer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx       <= 1'b1;
            shift_q  <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            div_q    <= 16'd1;
        end else begin
            tx       <= tx_d;
            shift_q  <= shift_d;
            bit_cnt  <= bit_cnt_d;
            baud_cnt <= baud_d;
            div_q    <= div_q_d;
        end
    end

endmodule
